mul_exec_unit: RTL and testbench
================================

# mul_exec_unit

Pipelined integer multiplier for the execute stage. It consumes the multiply packets that the multiply issue buffer sends each cycle and produces one result per cycle toward the CDB arbiter. It drives the `mul_busy` back-pressure signal that the multiply issue buffer reads. It tracks the branch mask of every in-flight op, so it honours squash (`clean_brat_en`) and mask-bit clear (`clean_bit_brat_en`) from the BRAT/EX exactly as the issue buffers do.

## Interface
Parameters:
- `XLEN`, 32, operand width
- `PREG_W`, 6, physical register tag width (log2 Preg_num)
- `BMASK_W`, 4, branch-mask width (width_b_mask)
- `CLR_N`, 2, number of mask-clear ports (ALU_num)
- `STAGES`, 4, pipeline depth; must divide `XLEN`

Ports:
- `clock` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-low
- `in_valid` in 1 — issue packet valid
- `in_func` in 2 — 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
- `in_rs1`, `in_rs2` in XLEN — operand values
- `in_dest` in PREG_W — destination physical register
- `in_b_mask` in BMASK_W — branch mask of the op
- `clean_brat_en` in 1 — squash every op whose mask has bit `clean_brat_num` set
- `clean_brat_num` in log2(BMASK_W)
- `clean_bit_brat_en` in CLR_N — per-port mask-bit clear enable
- `clean_bit_num_brat_ex` in CLR_N×log2(BMASK_W) — bit to clear, per port
- `cdb_grant` in 1 — arbiter accepts the result this cycle
- `mul_busy` out 1 — unit cannot accept this cycle
- `out_valid` out 1 — result valid
- `out_result` out XLEN — result
- `out_dest` out PREG_W
- `out_b_mask` out BMASK_W

## Operation
- Stage registers s[0..STAGES-1]. Each holds valid, func, dest, b_mask, multiplicand (sign-extended to 2·XLEN), remaining multiplier bits, and a 2·XLEN partial sum.
- Signedness: rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only. The product is computed as a 2·XLEN two's-complement product of the sign/zero-extended operands.
- Each stage adds XLEN/STAGES multiplier bits' worth of shifted partial products. Sign correction for a signed rs2 is applied in the last chunk.
- Result: MUL gives the low XLEN bits. MULH, MULHSU and MULHU give the high XLEN bits.
- Accept: `in_valid && !mul_busy` loads the packet into s[0]. If `in_valid` is high while `mul_busy` is high, the packet is ignored; the issue buffer must not do this.
- Stall: `stall = out_valid && !cdb_grant`, and `mul_busy = stall`. While stalled, every stage holds its contents; there is no bubble collapsing. Otherwise every stage advances one step per clock.
- Squash applies at every edge, stalled or not, to every stage and to the packet being accepted: the valid bit is cleared when `clean_brat_en && mask[clean_brat_num]`.
- Mask clear: for each i with `clean_bit_brat_en[i]`, bit `clean_bit_num_brat_ex[i]` is cleared in every stored mask and in the accepted mask.
- When squash and a clear target the same bit in the same cycle, squash wins for ops that already have that bit set.
- Outputs are combinational from the last stage, with the same-cycle squash and clears applied:
  - `out_valid = s[last].valid && !(clean_brat_en && s[last].mask[clean_brat_num])`
  - `out_b_mask` equals the stored mask with the current-cycle clears applied.
- A squashed last stage never asserts `out_valid`, so a grant in that cycle is ignored.

## Timing
- Reset (asynchronous assert, active-low): all valid bits and masks are 0. Outputs: `out_valid`=0, `mul_busy`=0, `out_result`/`out_dest`/`out_b_mask`=0.
- Latency: an op accepted in cycle N has `out_valid`=1 in cycle N+STAGES, i.e. cycle N+4 at the defaults, when not stalled.
- Throughput is one op per cycle. Order is strictly FIFO, with no reordering.
- Stall propagation is combinational: `cdb_grant`=0 with `out_valid`=1 raises `mul_busy` in the same cycle.
- A stall extends latency by exactly the number of stalled cycles.
- `mul_busy` falls in the first cycle where `out_valid`=0 or `cdb_grant`=1.
- Reset asserted mid-operation discards all in-flight ops immediately. The first accept is possible in the first cycle after deassertion.
- Grant while `out_valid`=0 has no effect.

## Test plan
- MUL 7×6, dest 5, accepted at cycle 0 → cycle 4: `out_valid`=1, `out_result`=42, `out_dest`=5. Cycle 5: `out_valid`=0.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Four back-to-back ops (dests 1–4), with `cdb_grant`=0 during cycles 4–6 → `mul_busy`=1 in cycles 4–6 and dest 1 is held. After grant returns, dests 1,2,3,4 come out in cycles 7–10.
- In flight: mask 0010 (dest 1) and mask 0001 (dest 2); pulse `clean_brat_en`, num=1 → only dest 2 completes, at its normal cycle.
- Accept an op with mask 0100 in the same cycle that port 0 clears bit 2; a later squash of bit 2 → the op still completes with `out_b_mask`=0000.
- Three ops in flight, then assert `reset` low for one cycle → no `out_valid` ever appears for them, and `mul_busy`=0. A fresh MUL 3×3 after release → 9 after 4 cycles.

Source files
------------

// File: rtl/mul_exec_unit.sv
// Pipelined integer multiplier for the execute stage: MUL/MULH/MULHSU/MULHU, one op per cycle,
// with branch-mask tracking, squash, mask-bit clears and CDB back-pressure.
module mul_exec_unit #(
  parameter int XLEN    = 32,
  parameter int PREG_W  = 6,
  parameter int BMASK_W = 4,
  parameter int CLR_N   = 2,
  parameter int STAGES  = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [1:0]                            in_func,
  input  logic [XLEN-1:0]                       in_rs1,
  input  logic [XLEN-1:0]                       in_rs2,
  input  logic [PREG_W-1:0]                     in_dest,
  input  logic [BMASK_W-1:0]                    in_b_mask,
  input  logic                                  clean_brat_en,
  input  logic [$clog2(BMASK_W)-1:0]            clean_brat_num,
  input  logic [CLR_N-1:0]                      clean_bit_brat_en,
  input  logic [CLR_N*$clog2(BMASK_W)-1:0]      clean_bit_num_brat_ex,
  input  logic                                  cdb_grant,
  output logic                                  mul_busy,
  output logic                                  out_valid,
  output logic [XLEN-1:0]                       out_result,
  output logic [PREG_W-1:0]                     out_dest,
  output logic [BMASK_W-1:0]                    out_b_mask
);

  localparam int BN_W = $clog2(BMASK_W);
  localparam int C    = XLEN / STAGES;
  localparam int L    = STAGES - 1;
  localparam int PW   = 2 * XLEN;

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;

  logic              r_valid  [STAGES];
  logic [1:0]        r_func   [STAGES];
  logic [PREG_W-1:0] r_dest   [STAGES];
  logic [BMASK_W-1:0] r_mask  [STAGES];
  logic [PW-1:0]     r_sum    [STAGES];
  // Multiplicand/multiplier are not needed once the last chunk has been summed.
  logic [PW-1:0]     r_mcand  [STAGES-1];
  logic [XLEN-1:0]   r_mplier [STAGES-1];

  logic              w_rs1_signed;
  logic [PW-1:0]     w_mcand0;
  logic              w_stall;

  function automatic logic [BMASK_W-1:0] f_clear(input logic [BMASK_W-1:0] m);
    logic [BMASK_W-1:0] res;
    res = m;
    for (int unsigned i = 0; i < CLR_N; i++) begin
      if (clean_bit_brat_en[i]) res[clean_bit_num_brat_ex[i*BN_W +: BN_W]] = 1'b0;
    end
    return res;
  endfunction

  function automatic logic f_kill(input logic [BMASK_W-1:0] m);
    return clean_brat_en && m[clean_brat_num];
  endfunction

  // A signed multiplier's top bit weighs -2^(XLEN-1), so its partial product is subtracted.
  function automatic logic [PW-1:0] f_pp(input logic [PW-1:0] mc, input logic [C-1:0] bits,
                                         input logic neg_top);
    logic [PW-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < C; j++) begin
      if (bits[j]) begin
        if (neg_top && (j == C - 1)) acc = acc - (mc << j);
        else                         acc = acc + (mc << j);
      end
    end
    return acc;
  endfunction

  assign w_rs1_signed = (in_func == F_MULH) || (in_func == F_MULHSU);
  assign w_mcand0     = {{XLEN{w_rs1_signed & in_rs1[XLEN-1]}}, in_rs1};

  assign out_valid  = r_valid[L] && !f_kill(r_mask[L]);
  assign w_stall    = out_valid && !cdb_grant;
  assign mul_busy   = w_stall;
  assign out_result = (r_func[L] == F_MUL) ? r_sum[L][XLEN-1:0] : r_sum[L][PW-1:XLEN];
  assign out_dest   = r_dest[L];
  assign out_b_mask = f_clear(r_mask[L]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_func[k]  <= '0;
        r_dest[k]  <= '0;
        r_mask[k]  <= '0;
        r_sum[k]   <= '0;
      end
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        r_mcand[k]  <= '0;
        r_mplier[k] <= '0;
      end
    end else if (w_stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k] && !f_kill(r_mask[k]);
        r_mask[k]  <= f_clear(r_mask[k]);
      end
    end else begin
      r_valid[0] <= in_valid && !f_kill(in_b_mask);
      r_func[0]  <= in_func;
      r_dest[0]  <= in_dest;
      r_mask[0]  <= f_clear(in_b_mask);
      r_sum[0]   <= f_pp(w_mcand0, in_rs2[C-1:0], (in_func == F_MULH) && (L == 0));
      if (STAGES > 1) begin
        r_mcand[0]  <= w_mcand0 << C;
        r_mplier[0] <= in_rs2 >> C;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1] && !f_kill(r_mask[k-1]);
        r_func[k]  <= r_func[k-1];
        r_dest[k]  <= r_dest[k-1];
        r_mask[k]  <= f_clear(r_mask[k-1]);
        r_sum[k]   <= r_sum[k-1] + f_pp(r_mcand[k-1], r_mplier[k-1][C-1:0],
                                        (r_func[k-1] == F_MULH) && (k == L));
      end
      for (int unsigned k = 1; k < STAGES - 1; k++) begin
        r_mcand[k]  <= r_mcand[k-1] << C;
        r_mplier[k] <= r_mplier[k-1] >> C;
      end
    end
  end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed bench for mul_exec_unit: table of arithmetic vectors plus hand-written
// stall, squash, mask-clear and reset sequences.
module tb_mul_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_func;
  logic [31:0] in_rs1, in_rs2;
  logic [5:0]  in_dest;
  logic [3:0]  in_b_mask;
  logic        clean_brat_en;
  logic [1:0]  clean_brat_num;
  logic [1:0]  clean_bit_brat_en;
  logic [3:0]  clean_bit_num_brat_ex;
  logic        cdb_grant;
  logic        mul_busy, out_valid;
  logic [31:0] out_result;
  logic [5:0]  out_dest;
  logic [3:0]  out_b_mask;

  int n_checks = 0;
  int n_fail   = 0;

  mul_exec_unit #(.XLEN(32), .PREG_W(6), .BMASK_W(4), .CLR_N(2), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_dest(in_dest), .in_b_mask(in_b_mask),
    .clean_brat_en(clean_brat_en), .clean_brat_num(clean_brat_num),
    .clean_bit_brat_en(clean_bit_brat_en), .clean_bit_num_brat_ex(clean_bit_num_brat_ex),
    .cdb_grant(cdb_grant), .mul_busy(mul_busy), .out_valid(out_valid),
    .out_result(out_result), .out_dest(out_dest), .out_b_mask(out_b_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_func = 2'd0; in_rs1 = '0; in_rs2 = '0; in_dest = '0; in_b_mask = '0;
    clean_brat_en = 1'b0; clean_brat_num = '0;
    clean_bit_brat_en = '0; clean_bit_num_brat_ex = '0;
    cdb_grant = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic iss(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [5:0] d, input logic [3:0] m);
    in_valid = 1'b1; in_func = f; in_rs1 = a; in_rs2 = b; in_dest = d; in_b_mask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{2'd0, 32'd7,        32'd6,        32'd42};
    vt[1]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vt[2]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vt[3]  = '{2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vt[4]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vt[5]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vt[6]  = '{2'd1, 32'h80000000, 32'd1,        32'hFFFFFFFF};
    vt[7]  = '{2'd1, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF};
    vt[8]  = '{2'd0, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFA};
    vt[9]  = '{2'd3, 32'h80000000, 32'd2,        32'h00000001};
    vt[10] = '{2'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
    vt[11] = '{2'd0, 32'h12345678, 32'h00000010, 32'h23456780};

    idle();
    reset = 1'b0;
    #12;
    @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", mul_busy, 0);
    chk("rst_result", out_result, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_mask", out_b_mask, 0);
    @(posedge clock); #1; reset = 1'b1;

    // Back-to-back arithmetic vectors, one result per cycle after 4-cycle latency.
    for (int t = 0; t < NV + 4; t++) begin
      nxt();
      if (t < NV) iss(vt[t].func, vt[t].a, vt[t].b, 6'(t + 1), 4'b0000);
      @(negedge clock);
      if (t >= 4) begin
        chk($sformatf("vec%0d_valid", t - 4), out_valid, 1);
        chk($sformatf("vec%0d_result", t - 4), out_result, vt[t-4].exp);
        chk($sformatf("vec%0d_dest", t - 4), out_dest, 6'(t - 3));
      end else begin
        chk("vec_lat_valid", out_valid, 0);
      end
    end
    nxt(); @(negedge clock);
    chk("vec_drain_valid", out_valid, 0);

    // Stall: no grant during cycles 4-6 holds the whole pipe.
    for (int t = 0; t <= 10; t++) begin
      nxt();
      if (t < 4) iss(2'd0, 32'(t + 1), 32'd10, 6'(t + 1), 4'b0000);
      if (t >= 4 && t <= 6) cdb_grant = 1'b0;
      @(negedge clock);
      if (t < 4) chk("stall_pre_valid", out_valid, 0);
      else if (t <= 6) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_busy", mul_busy, 1);
        chk("stall_dest", out_dest, 1);
      end else begin
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_busy", mul_busy, 0);
        chk("stall_out_dest", out_dest, 6'(t - 6));
        chk("stall_out_result", out_result, 32'((t - 6) * 10));
      end
    end

    // Squash of bit 1 kills dest 1 only.
    for (int t = 0; t <= 6; t++) begin
      nxt();
      if (t == 0) iss(2'd0, 32'd2, 32'd3, 6'd1, 4'b0010);
      if (t == 1) iss(2'd0, 32'd4, 32'd5, 6'd2, 4'b0001);
      if (t == 2) begin clean_brat_en = 1'b1; clean_brat_num = 2'd1; end
      @(negedge clock);
      if (t == 5) begin
        chk("sq_valid", out_valid, 1);
        chk("sq_dest", out_dest, 2);
        chk("sq_result", out_result, 20);
      end else chk("sq_idle_valid", out_valid, 0);
    end

    // Mask clear on accept, later squash, same-cycle output clear and output-stage squash.
    for (int t = 0; t <= 7; t++) begin
      nxt();
      if (t == 0) begin
        iss(2'd0, 32'd5, 32'd5, 6'd7, 4'b0100);
        clean_bit_brat_en = 2'b01; clean_bit_num_brat_ex = {2'd0, 2'd2};
      end
      if (t == 1) iss(2'd0, 32'd1, 32'd1, 6'd8, 4'b1000);
      if (t == 2) begin
        iss(2'd0, 32'd9, 32'd9, 6'd9, 4'b0001);
        clean_brat_en = 1'b1; clean_brat_num = 2'd2;
      end
      if (t == 6) begin clean_brat_en = 1'b1; clean_brat_num = 2'd0; end
      @(negedge clock);
      if (t == 4) begin
        chk("clr_valid", out_valid, 1);
        chk("clr_mask", out_b_mask, 4'b0000);
        chk("clr_result", out_result, 25);
        chk("clr_dest", out_dest, 7);
      end else if (t == 5) begin
        chk("msk_valid", out_valid, 1);
        chk("msk_mask", out_b_mask, 4'b1000);
        clean_bit_brat_en = 2'b10; clean_bit_num_brat_ex = {2'd3, 2'd0};
        #1;
        chk("msk_clr_now", out_b_mask, 4'b0000);
        chk("msk_clr_valid", out_valid, 1);
      end else if (t == 6) begin
        chk("outsq_valid", out_valid, 0);
        chk("outsq_busy", mul_busy, 0);
      end else chk("clr_idle_valid", out_valid, 0);
    end

    // Mid-flight reset discards everything; accept right after release.
    for (int t = 0; t <= 9; t++) begin
      nxt();
      if (t < 3) iss(2'd0, 32'(t + 2), 32'd3, 6'(t + 10), 4'b0000);
      if (t == 3) reset = 1'b0;
      if (t == 4) begin reset = 1'b1; iss(2'd0, 32'd3, 32'd3, 6'd6, 4'b0000); end
      @(negedge clock);
      if (t == 3) chk("rstm_busy", mul_busy, 0);
      if (t == 8) begin
        chk("rstm_new_valid", out_valid, 1);
        chk("rstm_new_result", out_result, 9);
        chk("rstm_new_dest", out_dest, 6);
      end else chk("rstm_valid", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
